// File: rtl/alu_bist.sv
// ALU built-in self-test initiator: 12 directed vectors with per-vector
// compare, then LFSR-driven random vectors compacted into a MISR signature.
module alu_bist #(
  parameter int unsigned N_RANDOM   = 256,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ALU_out,
  input  logic [31:0] flags,
  output logic [31:0] val_A,
  output logic [31:0] val_B,
  output logic [2:0]  ALU_op,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [31:0] sig
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;

  localparam bit          HAS_RND = (N_RANDOM != 0);
  localparam logic [31:0] LAST_R  = 32'(N_RANDOM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_D_APPLY, S_D_CHECK, S_R_APPLY, S_R_CHECK, S_FINISH
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
  } dvec_t;

  function automatic dvec_t dir_vec(input logic [3:0] i);
    dvec_t v;
    v = '0;
    case (i)
      4'd0:  v = {OP_ADD, 32'h3, 32'h1, 32'h4, 4'b0000};
      4'd1:  v = {OP_ADD, 32'h4000_0000, 32'h4000_0000,
                  32'h8000_0000, 4'b1001};
      4'd2:  v = {OP_SUB, 32'h7, 32'h3, 32'h4, 4'b0000};
      4'd3:  v = {OP_SUB, 32'h7, 32'h7, 32'h0, 4'b0100};
      4'd4:  v = {OP_AND, 32'h55, 32'hAA, 32'h0, 4'b0100};
      4'd5:  v = {OP_OR, 32'h55, 32'hAA, 32'hFF, 4'b0000};
      4'd6:  v = {OP_MUL, 32'h3, 32'h3, 32'h9, 4'b0000};
      4'd7:  v = {OP_MUL, 32'h8000_0000, 32'h8000_0000,
                  32'h0, 4'b0101};
      4'd8:  v = {OP_DIV, 32'h4, 32'h2, 32'h2, 4'b0000};
      4'd9:  v = {OP_DIV, 32'h4, 32'h0, 32'h0, 4'b0110};
      4'd10: v = {OP_NOT, 32'h0, 32'h3, 32'hFFFF_FFFC, 4'b1000};
      4'd11: v = {OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 4'b1000};
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t      r_state, w_nstate;
  logic [3:0]  r_idx;
  logic [31:0] r_rcnt;
  logic [31:0] r_lfsr, r_misr;
  logic [31:0] r_val_A, r_val_B, r_sig;
  logic [2:0]  r_ALU_op;
  logic        r_busy, r_done, r_pass;
  logic [3:0]  r_fail_count, r_ffi;

  logic [3:0]  w_app_idx;
  dvec_t       w_dv_app, w_dv_cur;
  logic [31:0] w_lfsr_nxt, w_rnd_src, w_misr_nxt;
  logic [2:0]  w_rnd_op;
  logic        w_d_mis, w_d_last, w_r_last;

  assign w_app_idx = (r_state == S_IDLE) ? 4'd0 : r_idx + 4'd1;
  assign w_dv_app  = dir_vec(w_app_idx);
  assign w_dv_cur  = dir_vec(r_idx);
  assign w_d_last  = (r_idx == 4'd11);
  assign w_r_last  = (r_rcnt == LAST_R);

  // Left-shift Galois form of x^32+x^22+x^2+x+1
  assign w_lfsr_nxt = {r_lfsr[30:0], 1'b0}
                    ^ (r_lfsr[31] ? 32'h0040_0007 : 32'h0);
  assign w_rnd_src  = (r_state == S_R_CHECK) ? w_lfsr_nxt : r_lfsr;
  assign w_rnd_op   = (&w_rnd_src[2:0]) ? OP_ADD : w_rnd_src[2:0];

  assign w_d_mis = (ALU_out != w_dv_cur.res)
                || (flags != {w_dv_cur.nzcv, 28'd0});
  assign w_misr_nxt = {r_misr[30:0],
                       r_misr[31] ^ r_misr[21] ^ r_misr[1] ^ r_misr[0]}
                    ^ ALU_out ^ flags;

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:    if (start && !r_done) w_nstate = S_D_APPLY;
      S_D_APPLY: w_nstate = S_D_CHECK;
      S_D_CHECK: begin
        if (!w_d_last)    w_nstate = S_D_APPLY;
        else if (HAS_RND) w_nstate = S_R_APPLY;
        else              w_nstate = S_FINISH;
      end
      S_R_APPLY: w_nstate = S_R_CHECK;
      S_R_CHECK: w_nstate = w_r_last ? S_FINISH : S_R_APPLY;
      S_FINISH:  w_nstate = S_IDLE;
      default:   w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 4'd0;
      r_rcnt       <= 32'd0;
      r_lfsr       <= LFSR_SEED;
      r_misr       <= 32'd0;
      r_val_A      <= 32'd0;
      r_val_B      <= 32'd0;
      r_ALU_op     <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= 4'd0;
      r_ffi        <= 4'hF;
      r_sig        <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (w_nstate == S_D_APPLY) begin
        r_idx    <= w_app_idx;
        r_val_A  <= w_dv_app.a;
        r_val_B  <= w_dv_app.b;
        r_ALU_op <= w_dv_app.op;
      end
      if (w_nstate == S_R_APPLY) begin
        r_val_A  <= w_rnd_src;
        r_val_B  <= {w_rnd_src[15:0], w_rnd_src[31:16]};
        r_ALU_op <= w_rnd_op;
      end
      case (r_state)
        S_IDLE: if (w_nstate == S_D_APPLY) begin
          r_busy       <= 1'b1;
          r_pass       <= 1'b0;
          r_sig        <= 32'd0;
          r_fail_count <= 4'd0;
          r_ffi        <= 4'hF;
          r_lfsr       <= LFSR_SEED;
          r_misr       <= 32'd0;
          r_rcnt       <= 32'd0;
        end
        S_D_CHECK: if (w_d_mis) begin
          if (r_fail_count != 4'hF) r_fail_count <= r_fail_count + 4'd1;
          if (r_ffi == 4'hF)        r_ffi        <= r_idx;
        end
        S_R_CHECK: begin
          r_misr <= w_misr_nxt;
          r_lfsr <= w_lfsr_nxt;
          r_rcnt <= r_rcnt + 32'd1;
        end
        S_FINISH: begin
          r_sig  <= r_misr;
          r_pass <= (r_fail_count == 4'd0)
                 && (!HAS_RND || (r_misr == GOLDEN_SIG));
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign val_A          = r_val_A;
  assign val_B          = r_val_B;
  assign ALU_op         = r_ALU_op;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_ffi;
  assign sig            = r_sig;

endmodule
